div_s: RTL and testbench

- Signed 16-bit sequential divider; the inverse operation to the ALU's signed Booth multiplier.
- Sits in the ALU of the UART calculator, alongside the multiplier, and uses the same start/dtype/done handshake.
- Computes quotient and remainder of dividend N / divisor D using a restoring algorithm on magnitudes, followed by a sign-fix step.
- Result is packed as {remainder, quotient}.

---
 rtl/div_s_pkg.sv | 15 +
 rtl/div_s.sv | 167 ++++++++++++++++
 tb/tb_div_s.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/div_s_pkg.sv
// Shared ALU definitions: operation codes, divider state encoding and default width.
package div_s_pkg;

  localparam int DIV_WIDTH = 16;

  localparam logic [3:0] DT_MUL = 4'h2;
  localparam logic [3:0] DT_DIV = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_s.sv
// Signed sequential divider: restoring division on magnitudes, then a sign-fix cycle.
// Handshake: start is taken only in IDLE when dtype matches; done pulses for one cycle with result/flags.
module div_s
  import div_s_pkg::*;
#(
  parameter int         WIDTH     = DIV_WIDTH,
  parameter logic [3:0] DTYPE_DIV = DT_DIV
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [WIDTH-1:0]   N,
  input  logic [WIDTH-1:0]   D,
  input  logic               start,
  input  logic [3:0]         dtype,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy,
  output logic               div_zero,
  output logic               ovf,
  output div_state_e         dbg_state
);

  localparam int               CW      = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? neg(v) : v;
  endfunction

  div_state_e         state_q, state_d;
  logic [WIDTH-1:0]   rmd_q, rmd_d;
  logic [WIDTH-1:0]   qm_q, qm_d;
  logic [WIDTH-1:0]   dmag_q, dmag_d;
  logic               sn_q, sn_d;
  logic               sd_q, sd_d;
  logic               dz_q, dz_d;
  logic               ovfp_q, ovfp_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               done_q, done_d;
  logic               divz_q, divz_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   r_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   n_back;

  assign r_sh    = {rmd_q[WIDTH-2:0], qm_q[WIDTH-1]};
  assign trial   = {rmd_q[WIDTH-1], r_sh} - {1'b0, dmag_q};
  assign quo_fix = (sn_q ^ sd_q) ? neg(qm_q) : qm_q;
  assign rem_fix = sn_q ? neg(rmd_q) : rmd_q;
  // On divide-by-zero no step runs, so qm_q still holds |N|; restoring the sign recovers N.
  assign n_back  = sn_q ? neg(qm_q) : qm_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      rmd_q    <= '0;
      qm_q     <= '0;
      dmag_q   <= '0;
      sn_q     <= 1'b0;
      sd_q     <= 1'b0;
      dz_q     <= 1'b0;
      ovfp_q   <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rmd_q    <= rmd_d;
      qm_q     <= qm_d;
      dmag_q   <= dmag_d;
      sn_q     <= sn_d;
      sd_q     <= sd_d;
      dz_q     <= dz_d;
      ovfp_q   <= ovfp_d;
      count_q  <= count_d;
      result_q <= result_d;
      done_q   <= done_d;
      divz_q   <= divz_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rmd_d    = rmd_q;
    qm_d     = qm_q;
    dmag_d   = dmag_q;
    sn_d     = sn_q;
    sd_d     = sd_q;
    dz_d     = dz_q;
    ovfp_d   = ovfp_q;
    count_d  = count_q;
    result_d = result_q;
    done_d   = 1'b0;
    divz_d   = divz_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && (dtype == DTYPE_DIV)) begin
          sn_d    = N[WIDTH-1];
          sd_d    = D[WIDTH-1];
          qm_d    = mag(N);
          dmag_d  = mag(D);
          rmd_d   = '0;
          dz_d    = (D == '0);
          ovfp_d  = (N == MIN_NEG) && (D == '1);
          // A zero divisor skips every step but still spends the terminal-count cycle,
          // which keeps the two latencies a fixed 16 cycles apart.
          count_d = (D == '0) ? '0 : CW'(WIDTH);
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        if (count_q != '0) begin
          if (!trial[WIDTH]) begin
            rmd_d = trial[WIDTH-1:0];
            qm_d  = {qm_q[WIDTH-2:0], 1'b1};
          end else begin
            rmd_d = r_sh;
            qm_d  = {qm_q[WIDTH-2:0], 1'b0};
          end
          count_d = count_q - CNT_ONE;
        end else begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        done_d = 1'b1;
        if (dz_q) begin
          result_d = {n_back, {WIDTH{1'b1}}};
          divz_d   = 1'b1;
          ovf_d    = 1'b0;
        end else begin
          result_d = {rem_fix, quo_fix};
          divz_d   = 1'b0;
          ovf_d    = ovfp_q;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign div_zero  = divz_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_s.sv
// Directed and random stimulus for div_s with a queue of expected {result, div_zero, ovf}.
module tb_div_s;
  import div_s_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [W-1:0] N = '0;
  logic [W-1:0] D = '0;
  logic         start = 1'b0;
  logic [3:0]   dtype = '0;
  logic [2*W-1:0] result;
  logic         done;
  logic         busy;
  logic         div_zero;
  logic         ovf;
  div_state_e   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W+1:0] exp_q[$];

  div_s #(.WIDTH(W), .DTYPE_DIV(DT_DIV)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .N        (N),
    .D        (D),
    .start    (start),
    .dtype    (dtype),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .div_zero (div_zero),
    .ovf      (ovf),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference from the language's truncating division; remainder follows the dividend.
  function automatic logic [2*W+1:0] model(input logic [W-1:0] n, input logic [W-1:0] d);
    int ni;
    int di;
    int q;
    int r;
    logic [W-1:0] qv;
    logic [W-1:0] rv;
    ni = int'($signed(n));
    di = int'($signed(d));
    if (d == '0) return {n, 16'hFFFF, 1'b1, 1'b0};
    q  = ni / di;
    r  = ni % di;
    qv = q[W-1:0];
    rv = r[W-1:0];
    return {rv, qv, 1'b0, (ni == -32768) && (di == -1)};
  endfunction

  task automatic launch(input logic [W-1:0] n, input logic [W-1:0] d);
    @(negedge clk);
    N     = n;
    D     = d;
    dtype = DT_DIV;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    N     = W'($urandom);
    D     = W'($urandom);
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic collect(input string tag, input int exp_lat);
    int lat;
    logic [2*W+1:0] got;
    logic [2*W+1:0] e;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (done) lat = k;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (lat != 0) begin
      got = {result, div_zero, ovf};
      chk(tag, 64'(got), 64'(e));
      chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                        input logic [2*W+1:0] expv, input int exp_lat);
    exp_q.push_back(expv);
    launch(n, d);
    collect(tag, exp_lat);
  endtask

  task automatic count_dones(input int cycles, output int cnt, output int busy_cnt);
    cnt = 0;
    busy_cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
      if (busy) busy_cnt++;
    end
  endtask

  initial begin
    int nd;
    int nb;
    logic [W-1:0] rn;
    logic [W-1:0] rd;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_flags", 64'({done, busy, div_zero, ovf}), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    n_rst = 1'b1;

    run_op("pos_pos",     16'h0064, 16'h0007, {32'h0002_000E, 1'b0, 1'b0}, 18);
    run_op("neg_pos",     16'hFF9C, 16'h0007, {32'hFFFE_FFF2, 1'b0, 1'b0}, 18);
    run_op("pos_neg",     16'h0064, 16'hFFF9, {32'h0002_FFF2, 1'b0, 1'b0}, 18);
    run_op("min_by_m1",   16'h8000, 16'hFFFF, {32'h0000_8000, 1'b0, 1'b1}, 18);
    run_op("min_by_1",    16'h8000, 16'h0001, {32'h0000_8000, 1'b0, 1'b0}, 18);
    run_op("div_zero",    16'h1234, 16'h0000, {32'h1234_FFFF, 1'b1, 1'b0}, 2);
    run_op("neg_by_zero", 16'h8001, 16'h0000, {32'h8001_FFFF, 1'b1, 1'b0}, 2);
    run_op("neg_neg",     16'hFF9C, 16'hFFF9, {32'hFFFE_000E, 1'b0, 1'b0}, 18);

    for (int i = 0; i < 6; i++) begin
      rn = W'($urandom_range(0, 65535));
      rd = (i % 2 == 0) ? W'($urandom_range(0, 65535)) : W'($urandom_range(1, 20));
      run_op("random", rn, rd, model(rn, rd), (rd == '0) ? 2 : 18);
    end

    // Another ALU op code must not start the divider.
    @(negedge clk);
    N     = 16'h0005;
    D     = 16'h0001;
    dtype = DT_MUL;
    start = 1'b1;
    count_dones(3, nd, nb);
    @(negedge clk);
    start = 1'b0;
    count_dones(25, nd, nb);
    chk("mul_dtype_busy", 64'(nb), 64'd0);
    chk("mul_dtype_done", 64'(nd), 64'd0);

    // A second start mid-calculation is ignored; only the first operands complete.
    exp_q.push_back({32'h0001_0006, 1'b0, 1'b0});
    launch(16'h0019, 16'h0004);
    repeat (5) @(posedge clk);
    @(negedge clk);
    N     = 16'h0100;
    D     = 16'h0003;
    dtype = DT_DIV;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    collect("restart_ignored", 12);
    count_dones(25, nd, nb);
    chk("restart_single_done", 64'(nd), 64'd0);

    // Reset mid-calculation abandons the operation and clears the outputs at once.
    launch(16'h7FFF, 16'h0003);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("midreset_result", 64'(result), 64'd0);
    chk("midreset_flags", 64'({done, busy, div_zero, ovf}), 64'd0);
    chk("midreset_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    n_rst = 1'b1;
    count_dones(25, nd, nb);
    chk("midreset_no_done", 64'(nd), 64'd0);
    run_op("after_reset", 16'h0009, 16'h0003, {32'h0000_0003, 1'b0, 1'b0}, 18);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
